// File: rtl/bth_op_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : bth_op_seq_pkg
// Brief  : Shared state encodings, default widths and clog2 helper for the
//          Booth operand sequencer.
// Rev    : 1.0
// ============================================================================
package bth_op_seq_pkg;

    localparam int c_N_DEF = 8;
    localparam int c_n_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bth_op_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module : bth_op_seq_fifo
// Brief  : Operand-pair FIFO with registered count, full and empty flags.
// Rev    : 1.0
// ============================================================================
module bth_op_seq_fifo
    import bth_op_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr;
    logic [c_AW-1:0]  r_rd;
    logic [c_CW-1:0]  r_cnt;
    logic [c_CW-1:0]  w_cnt_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    // A push while full is dropped even when a pop lands on the same edge.
    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & ~r_empty;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + c_CW'(1);
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_cnt - c_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wr <= r_wr + c_AW'(1);
            if (w_pop)  r_rd <= r_rd + c_AW'(1);
            r_cnt   <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == c_CW'(DEPTH));
            r_empty <= (w_cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/bth_op_seq.sv
`default_nettype none
// ============================================================================
// Module : bth_op_seq
// Brief  : Queues operand pairs, issues them one at a time to the Booth
//          multiplier and streams products out in order.
//          Optional macro BTH_SEQ_TIMEOUT_EN adds a WAIT-state timeout.
// Rev    : 1.0
// ============================================================================
module bth_op_seq
    import bth_op_seq_pkg::*;
#(
    parameter int N         = c_N_DEF,
    parameter int n         = c_n_DEF,
    parameter int DEPTH     = 4,
    parameter int START_CYC = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_a,
    input  logic [n-1:0] in_b,
    output logic         mul_start,
    output logic [n-1:0] mul_a,
    output logic [n-1:0] mul_b,
    input  logic         mul_done,
    input  logic [N-1:0] mul_p,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_p,
    output logic         busy,
    output logic         out_err
);

    localparam int c_SCW = clog2(START_CYC + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [c_SCW-1:0] r_cnt;
    logic [c_SCW-1:0] w_cnt_nxt;
    logic             r_start;
    logic             w_start_nxt;
    logic [n-1:0]     r_a;
    logic [n-1:0]     w_a_nxt;
    logic [n-1:0]     r_b;
    logic [n-1:0]     w_b_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic [N-1:0]     r_p;
    logic [N-1:0]     w_p_nxt;
    logic             w_pop;
    logic [2*n-1:0]   w_rdata;
    logic             w_full;
    logic             w_empty;

`ifdef BTH_SEQ_TIMEOUT_EN
    localparam int c_TCW = clog2(TIMEOUT + 1);
    logic [c_TCW-1:0] r_tcnt;
    logic [c_TCW-1:0] w_tcnt_nxt;
    logic             r_err;
    logic             w_err_nxt;
`else
    localparam int c_TIMEOUT_UNUSED = TIMEOUT;
`endif

    bth_op_seq_fifo #(
        .WIDTH (2 * n),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (in_valid),
        .i_wdata ({in_a, in_b}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_start_nxt = r_start;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_valid_nxt = r_valid;
        w_p_nxt     = r_p;
`ifdef BTH_SEQ_TIMEOUT_EN
        w_tcnt_nxt  = r_tcnt;
        w_err_nxt   = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop              = 1'b1;
                    {w_a_nxt, w_b_nxt} = w_rdata;
                    w_start_nxt        = 1'b1;
                    w_cnt_nxt          = c_SCW'(START_CYC - 1);
                    w_state_nxt        = S_ISSUE;
                end
            end
            // done is ignored here so a level left over from the last op is flushed
            S_ISSUE: begin
                if (r_cnt == '0) begin
                    w_start_nxt = 1'b0;
                    w_state_nxt = S_WAIT;
`ifdef BTH_SEQ_TIMEOUT_EN
                    w_tcnt_nxt  = '0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - c_SCW'(1);
                end
            end
            S_WAIT: begin
                if (mul_done) begin
                    w_p_nxt     = mul_p;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_OUT;
                end
`ifdef BTH_SEQ_TIMEOUT_EN
                else if (r_tcnt == c_TCW'(TIMEOUT - 1)) begin
                    w_p_nxt     = '0;
                    w_valid_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_OUT;
                end else begin
                    w_tcnt_nxt = r_tcnt + c_TCW'(1);
                end
`endif
            end
            S_OUT: begin
                if (out_ready) begin
                    w_valid_nxt = 1'b0;
`ifdef BTH_SEQ_TIMEOUT_EN
                    w_err_nxt   = 1'b0;
`endif
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_start <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_p     <= '0;
`ifdef BTH_SEQ_TIMEOUT_EN
            r_tcnt  <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_start <= w_start_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_valid <= w_valid_nxt;
            r_p     <= w_p_nxt;
`ifdef BTH_SEQ_TIMEOUT_EN
            r_tcnt  <= w_tcnt_nxt;
            r_err   <= w_err_nxt;
`endif
        end
    end

    assign in_ready  = ~w_full;
    assign mul_start = r_start;
    assign mul_a     = r_a;
    assign mul_b     = r_b;
    assign out_valid = r_valid;
    assign out_p     = r_p;
    assign busy      = (r_state != S_IDLE) | ~w_empty;
`ifdef BTH_SEQ_TIMEOUT_EN
    assign out_err   = r_err;
`else
    assign out_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bth_op_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_bth_op_seq
// Brief  : Self-checking bench for bth_op_seq with a behavioural multiplier.
// Rev    : 1.0
// ============================================================================
module tb_bth_op_seq;

    localparam int N = 8;
    localparam int NW = 4;
    localparam int DEPTH = 4;
    localparam int START_CYC = 3;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NW-1:0] in_a = '0;
    logic [NW-1:0] in_b = '0;
    logic          mul_start;
    logic [NW-1:0] mul_a;
    logic [NW-1:0] mul_b;
    logic          mul_done = 1'b0;
    logic [N-1:0]  mul_p = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  out_p;
    logic          busy;
    logic          out_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bth_op_seq #(
        .N(N), .n(NW), .DEPTH(DEPTH), .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mul_start(mul_start), .mul_a(mul_a),
        .mul_b(mul_b), .mul_done(mul_done), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .busy(busy), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Signed 4x4 product, the value a Booth multiplier delivers on P.
    function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (a[3]) sa = sa - 16;
        if (b[3]) sb = sb - 16;
        return 8'(sa * sb);
    endfunction

    // Behavioural multiplier: done drops while start is high, rises after a latency.
    int       lat_min = 1;
    int       lat_max = 4;
    bit       hang = 1'b0;
    bit       mm_pend = 1'b0;
    int       mm_lat = 0;
    logic [3:0] mm_a = '0;
    logic [3:0] mm_b = '0;
    always @(negedge clk) begin
        if (!reset) begin
            mul_done = 1'b0;
            mm_pend = 1'b0;
        end else if (mul_start) begin
            mul_done = 1'b0;
            mm_a = mul_a;
            mm_b = mul_b;
            mm_pend = 1'b1;
            mm_lat = $urandom_range(lat_max, lat_min);
        end else if (mm_pend && !hang) begin
            if (mm_lat <= 1) begin
                mul_done = 1'b1;
                mul_p = prod(mm_a, mm_b);
                mm_pend = 1'b0;
            end else begin
                mm_lat = mm_lat - 1;
            end
        end
    end

    // Event log: what the DUT did and on which clock edge.
    logic [7:0] iss_q[$];
    int         iss_edge_q[$];
    int         len_q[$];
    int         fall_edge_q[$];
    int         push_edge_q[$];
    int         acc_edge_q[$];
    int         vrise_q[$];
    logic [8:0] got_q[$];
    int         unstable = 0;
    int         run_len = 0;
    bit         prev_start = 1'b0;
    bit         prev_valid = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            if (in_valid && in_ready) push_edge_q.push_back(cyc + 1);
            if (mul_start && !prev_start) begin
                iss_q.push_back({mul_a, mul_b});
                iss_edge_q.push_back(cyc);
                run_len = 0;
            end
            if (mul_start) begin
                run_len++;
                if ({mul_a, mul_b} != iss_q[$]) unstable++;
            end
            if (!mul_start && prev_start) begin
                len_q.push_back(run_len);
                fall_edge_q.push_back(cyc);
            end
            if (out_valid && !prev_valid) vrise_q.push_back(cyc);
            if (out_valid && out_ready) begin
                got_q.push_back({out_err, out_p});
                acc_edge_q.push_back(cyc + 1);
            end
            prev_start = mul_start;
            prev_valid = out_valid;
        end else begin
            prev_start = 1'b0;
            prev_valid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        iss_q.delete(); iss_edge_q.delete(); len_q.delete(); fall_edge_q.delete();
        push_edge_q.delete(); acc_edge_q.delete(); vrise_q.delete(); got_q.delete();
        unstable = 0;
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b);
        bit done;
        done = 1'b0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            done = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL push_timeout a=%0h b=%0h", a, b);
        end
    endtask

    task automatic wait_got(input int cnt, input int budget);
        int i;
        for (i = 0; i < budget && got_q.size() < cnt; i++) step();
        if (got_q.size() < cnt) begin
            checks++; errors++;
            $display("FAIL result_timeout got %0d results, required %0d", got_q.size(), cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks += 5;
        if (mul_start !== 1'b0) begin errors++; $display("FAIL rst_mul_start got %b exp 0", mul_start); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        if (out_p !== 8'h00) begin errors++; $display("FAIL rst_out_p got %h exp 00", out_p); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err got %b exp 0", out_err); end
        reset = 1'b1;
        step();
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_post got %b exp 0", busy); end
    endtask

    task automatic test_single();
        clear_log();
        out_ready = 1'b1;
        push(4'd10, 4'd1);
        wait_got(1, 100);
        repeat (2) step();
        checks += 6;
        if (iss_q.size() != 1 || iss_q[0] !== 8'hA1) begin
            errors++; $display("FAIL single_issue got n=%0d pair=%h exp n=1 pair=a1", iss_q.size(), iss_q[0]);
        end
        if (len_q.size() != 1 || len_q[0] != START_CYC) begin
            errors++; $display("FAIL single_start_len got %0d exp %0d", len_q[0], START_CYC);
        end
        if (unstable != 0) begin errors++; $display("FAIL single_operand_stable got %0d changes exp 0", unstable); end
        if (got_q.size() != 1 || got_q[0] !== {1'b0, prod(4'd10, 4'd1)}) begin
            errors++; $display("FAIL single_product got %h exp %h", got_q[0], {1'b0, prod(4'd10, 4'd1)});
        end
        if (iss_edge_q.size() != 1 || push_edge_q.size() != 1 || iss_edge_q[0] - push_edge_q[0] != 1) begin
            errors++; $display("FAIL single_latency got %0d exp 1", iss_edge_q[0] - push_edge_q[0]);
        end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy); end
    endtask

    task automatic test_burst();
        logic [7:0] exp_q[$];
        logic [7:0] pairs[4];
        int i;
        clear_log();
        pairs[0] = 8'h32; pairs[1] = 8'h75; pairs[2] = 8'hFF; pairs[3] = 8'h09;
        out_ready = 1'b0;
        exp_q.push_back(8'($urandom));
        push(exp_q[0][7:4], exp_q[0][3:0]);
        for (i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL burst_ready_before_%0d got %b exp 1", i, in_ready); end
            exp_q.push_back(pairs[i]);
            push(pairs[i][7:4], pairs[i][3:0]);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL burst_full got in_ready=%b exp 0", in_ready); end
        in_a = 4'd5; in_b = 4'd5; in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_got(5, 400);
        repeat (10) step();
        checks += 2;
        if (got_q.size() != 5) begin errors++; $display("FAIL burst_count got %0d exp 5", got_q.size()); end
        if (iss_q.size() != 5) begin errors++; $display("FAIL burst_issue_count got %0d exp 5", iss_q.size()); end
        for (i = 0; i < 5 && i < got_q.size() && i < iss_q.size(); i++) begin
            checks += 2;
            if (iss_q[i] !== exp_q[i]) begin errors++; $display("FAIL burst_issue_%0d got %h exp %h", i, iss_q[i], exp_q[i]); end
            if (got_q[i] !== {1'b0, prod(exp_q[i][7:4], exp_q[i][3:0])}) begin
                errors++; $display("FAIL burst_result_%0d got %h exp %h", i, got_q[i], {1'b0, prod(exp_q[i][7:4], exp_q[i][3:0])});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] op0;
        logic [7:0] op1;
        logic [7:0] hold;
        int bad;
        int i;
        clear_log();
        op0 = 8'($urandom);
        op1 = 8'($urandom);
        out_ready = 1'b0;
        push(op0[7:4], op0[3:0]);
        push(op1[7:4], op1[3:0]);
        for (i = 0; i < 100 && !out_valid; i++) step();
        hold = out_p;
        bad = 0;
        for (i = 0; i < 20; i++) begin
            step();
            if (out_valid !== 1'b1 || out_p !== hold) bad++;
        end
        checks += 3;
        if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d unstable cycles exp 0", bad); end
        if (iss_q.size() != 1) begin errors++; $display("FAIL bp_no_issue got %0d issues exp 1", iss_q.size()); end
        if (hold !== prod(op0[7:4], op0[3:0])) begin errors++; $display("FAIL bp_product got %h exp %h", hold, prod(op0[7:4], op0[3:0])); end
        out_ready = 1'b1;
        wait_got(2, 100);
        checks += 2;
        if (iss_edge_q.size() < 2 || acc_edge_q.size() < 1 || iss_edge_q[1] - acc_edge_q[0] != 1) begin
            errors++; $display("FAIL bp_reissue_edge got %0d exp 1", iss_edge_q[1] - acc_edge_q[0]);
        end
        if (got_q.size() < 2 || got_q[1] !== {1'b0, prod(op1[7:4], op1[3:0])}) begin
            errors++; $display("FAIL bp_second got %h exp %h", got_q[1], {1'b0, prod(op1[7:4], op1[3:0])});
        end
        repeat (3) step();
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] op;
        int nops;
        nops = 12;
        clear_log();
        lat_min = 1;
        lat_max = 7;
        fork
            begin
                for (int k = 0; k < nops; k++) begin
                    op = 8'($urandom);
                    exp_q.push_back(op);
                    repeat ($urandom_range(2, 0)) step();
                    push(op[7:4], op[3:0]);
                end
            end
            begin
                for (int c = 0; c < 3000 && got_q.size() < nops; c++) begin
                    out_ready = 1'($urandom_range(1, 0));
                    step();
                end
                out_ready = 1'b1;
            end
        join
        checks++;
        if (got_q.size() != nops) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), nops); end
        for (int k = 0; k < nops && k < got_q.size() && k < iss_q.size(); k++) begin
            checks += 2;
            if (iss_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_issue_%0d got %h exp %h", k, iss_q[k], exp_q[k]); end
            if (got_q[k] !== {1'b0, prod(exp_q[k][7:4], exp_q[k][3:0])}) begin
                errors++; $display("FAIL rand_result_%0d got %h exp %h", k, got_q[k], {1'b0, prod(exp_q[k][7:4], exp_q[k][3:0])});
            end
        end
        lat_min = 1;
        lat_max = 4;
        repeat (3) step();
    endtask

    task automatic test_reset_mid();
        int i;
        clear_log();
        out_ready = 1'b1;
        lat_min = 12;
        lat_max = 12;
        push(4'd3, 4'd4);
        push(4'd5, 4'd6);
        push(4'd7, 4'd2);
        for (i = 0; i < 50 && fall_edge_q.size() < 1; i++) step();
        step();
        #1 reset = 1'b0;
        #1;
        checks += 6;
        if (mul_start !== 1'b0) begin errors++; $display("FAIL mid_mul_start got %b exp 0", mul_start); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
        if (out_p !== 8'h00) begin errors++; $display("FAIL mid_out_p got %h exp 00", out_p); end
        if (mul_a !== 4'h0 || mul_b !== 4'h0) begin errors++; $display("FAIL mid_operands got %h%h exp 00", mul_a, mul_b); end
        if (fall_edge_q.size() != 1) begin errors++; $display("FAIL mid_reached_wait got %0d exp 1", fall_edge_q.size()); end
        repeat (2) step();
        reset = 1'b1;
        lat_min = 1;
        lat_max = 4;
        repeat (8) step();
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after got %b exp 0", busy); end
        if (iss_q.size() != 1) begin errors++; $display("FAIL mid_fifo_flushed got %0d issues exp 1", iss_q.size()); end
        if (got_q.size() != 0) begin errors++; $display("FAIL mid_no_result got %0d exp 0", got_q.size()); end
    endtask

`ifdef BTH_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int i;
        clear_log();
        hang = 1'b1;
        out_ready = 1'b0;
        push(4'd6, 4'd3);
        push(4'd5, 4'd7);
        for (i = 0; i < 300 && !out_valid; i++) step();
        checks += 3;
        if (out_err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", out_err); end
        if (out_p !== 8'h00) begin errors++; $display("FAIL to_out_p got %h exp 00", out_p); end
        if (vrise_q.size() < 1 || fall_edge_q.size() < 1 || vrise_q[0] - fall_edge_q[0] != TIMEOUT) begin
            errors++; $display("FAIL to_wait_cycles got %0d exp %0d", vrise_q[0] - fall_edge_q[0], TIMEOUT);
        end
        hang = 1'b0;
        out_ready = 1'b1;
        wait_got(2, 100);
        checks += 2;
        if (got_q.size() < 1 || got_q[0] !== 9'h100) begin errors++; $display("FAIL to_first got %h exp 100", got_q[0]); end
        if (got_q.size() < 2 || got_q[1] !== {1'b0, prod(4'd5, 4'd7)}) begin
            errors++; $display("FAIL to_next got %h exp %h", got_q[1], {1'b0, prod(4'd5, 4'd7)});
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef BTH_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
